muldiv_controller: RTL and testbench

- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU, plus the HI/LO register pair, alongside the single-cycle EX ALU.
- Accepts an operation from EX and holds the pipeline with a stall request while a radix-2 iterative multiply or restoring divide runs.
- Commits the 64-bit result to HI/LO.
- Also services MTHI/MTLO writes; hi/lo outputs feed MFHI/MFLO selection in EX.

---
 rtl/muldiv_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_muldiv_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_controller.sv
// =============================================================================
// muldiv_controller : iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO pair
// Revision: 1.0
// =============================================================================
`default_nettype none

module muldiv_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] operand_1,
   input  logic [WIDTH-1:0] operand_2,
   input  logic             flush,
   output logic             stall_request,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MTLO  = 6'h13;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;

   // rem_q/quo_q form the {upper,lower} working pair for both algorithms;
   // mag_q holds the multiplicand or divisor magnitude.
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             dbz_q, dbz_d;

   logic             w_is_mul;
   logic             w_is_div;
   logic             w_signed;
   logic [WIDTH-1:0] w_abs1;
   logic [WIDTH-1:0] w_abs2;

   logic [WIDTH:0]   w_msum;
   logic [WIDTH-1:0] w_mul_rem;
   logic [WIDTH-1:0] w_mul_quo;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_s;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;
   logic [WIDTH-1:0] w_div_rem;
   logic [WIDTH-1:0] w_div_quo;
   logic [WIDTH-1:0] w_quo_s;
   logic [WIDTH-1:0] w_rem_s;

   // Operation decode; signed variants have funct[0] clear.
   assign w_is_mul = (funct == FN_MULT) || (funct == FN_MULTU);
   assign w_is_div = (funct == FN_DIV)  || (funct == FN_DIVU);
   assign w_signed = ~funct[0];
   assign w_abs1   = (w_signed && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
   assign w_abs2   = (w_signed && operand_2[WIDTH-1]) ? -operand_2 : operand_2;

   // Shift-add multiply step: carry out of the add lands in the upper half.
   assign w_msum    = {1'b0, rem_q} + (quo_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
   assign w_mul_rem = w_msum[WIDTH:1];
   assign w_mul_quo = {w_msum[0], quo_q[WIDTH-1:1]};
   assign w_prod    = {w_mul_rem, w_mul_quo};
   assign w_prod_s  = neg_q ? -w_prod : w_prod;

   // Restoring divide step.
   assign w_shift = {rem_q, quo_q[WIDTH-1]};
   assign w_diff  = {1'b0, w_shift} - {2'b00, mag_q};

   always_comb begin
      w_div_rem = w_shift[WIDTH-1:0];
      w_div_quo = {quo_q[WIDTH-2:0], 1'b0};
      if (!w_diff[WIDTH+1]) begin
         w_div_rem = w_diff[WIDTH-1:0];
         w_div_quo = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   assign w_quo_s = neg_q  ? -w_div_quo : w_div_quo;
   assign w_rem_s = rneg_q ? -w_div_rem : w_div_rem;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      mag_d         = mag_q;
      opa_d         = opa_q;
      neg_d         = neg_q;
      rneg_d        = rneg_q;
      dbz_d         = dbz_q;
      stall_request = 1'b0;

      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (w_is_mul || w_is_div) begin
                     stall_request = 1'b1;
                     state_d       = w_is_mul ? S_MUL : S_DIV;
                     cnt_d         = '0;
                     opa_d         = operand_1;
                     neg_d         = w_signed && (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
                     rneg_d        = w_signed && operand_1[WIDTH-1];
                     dbz_d         = (operand_2 == '0);
                     rem_d         = '0;
                     quo_d         = w_is_mul ? w_abs2 : w_abs1;
                     mag_d         = w_is_mul ? w_abs1 : w_abs2;
                  end else if (funct == FN_MTHI) begin
                     hi_d = operand_1;
                  end else if (funct == FN_MTLO) begin
                     lo_d = operand_1;
                  end
               end
            end
            S_MUL: begin
               stall_request = 1'b1;
               cnt_d         = cnt_q + CNT_W'(1);
               rem_d         = w_mul_rem;
               quo_d         = w_mul_quo;
               if (cnt_q == LAST_ITER) begin
                  hi_d    = w_prod_s[2*WIDTH-1:WIDTH];
                  lo_d    = w_prod_s[WIDTH-1:0];
                  cnt_d   = '0;
                  state_d = S_DONE;
               end
            end
            S_DIV: begin
               stall_request = 1'b1;
               cnt_d         = cnt_q + CNT_W'(1);
               rem_d         = w_div_rem;
               quo_d         = w_div_quo;
               if (cnt_q == LAST_ITER) begin
                  // A zero divisor still runs every iteration, then overrides.
                  if (dbz_q) begin
                     hi_d = opa_q;
                     lo_d = '1;
                  end else begin
                     hi_d = w_rem_s;
                     lo_d = w_quo_s;
                  end
                  cnt_d   = '0;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (rst) begin
         stall_request = 1'b0;
      end
   end

   assign busy_d = (state_d == S_MUL) || (state_d == S_DIV);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         mag_q   <= '0;
         opa_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         mag_q   <= mag_d;
         opa_q   <= opa_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_controller.sv
// =============================================================================
// tb_muldiv_controller : directed + randomized checks against an arithmetic model
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_muldiv_controller;

   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MTLO  = 6'h13;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  funct;
   logic [31:0] operand_1;
   logic [31:0] operand_2;
   logic        flush;
   logic        stall_request;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   muldiv_controller #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .funct         (funct),
      .operand_1     (operand_1),
      .operand_2     (operand_2),
      .flush         (flush),
      .stall_request (stall_request),
      .busy          (busy),
      .hi            (hi),
      .lo            (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference result {hi,lo} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, p;
      logic [31:0] uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         FN_MULT:  begin p = sa * sb; return p; end
         FN_MULTU: begin p = ua * ub; return p; end
         FN_DIVU: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            uq = a / b;
            ur = a % b;
            return {ur, uq};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [5];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'h8000_0000;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h0000_0001;
      specials[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   task automatic run_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      int          n;
      exp = model(f, a, b);
      @(negedge clk);
      start = 1'b1; funct = f; operand_1 = a; operand_2 = b;
      #1;
      n = 0;
      while (stall_request && n < 100) begin
         n++;
         @(negedge clk);
         if (n == 1) chk("busy_run", {63'd0, busy}, 64'd1);
         operand_1 = $urandom;
         operand_2 = $urandom;
         #1;
      end
      chk("stall_cycles", 64'(n), 64'd33);
      chk("busy_done", {63'd0, busy}, 64'd0);
      chk("hilo_result", {hi, lo}, exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      @(negedge clk);
      chk("no_restart", {63'd0, busy}, 64'd0);
      start = 1'b0;
      funct = 6'h00;
   endtask

   task automatic run_single(input logic [5:0] f, input logic [31:0] a);
      @(negedge clk);
      start = 1'b1; funct = f; operand_1 = a; operand_2 = $urandom;
      #1;
      chk("stall_single", {63'd0, stall_request}, 64'd0);
      if (f == FN_MTHI) m_hi = a;
      if (f == FN_MTLO) m_lo = a;
      @(negedge clk);
      start = 1'b0;
      chk("hilo_single", {hi, lo}, {m_hi, m_lo});
   endtask

   initial begin
      logic [5:0]  fsel [4];
      logic [5:0]  f;
      int          k;
      fsel[0] = FN_MULT; fsel[1] = FN_MULTU; fsel[2] = FN_DIV; fsel[3] = FN_DIVU;

      rst = 1'b1; start = 1'b1; funct = FN_MULT; flush = 1'b0;
      operand_1 = 32'd5; operand_2 = 32'd6;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      chk("stall_in_reset", {63'd0, stall_request}, 64'd0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      chk("reset_stall", {63'd0, stall_request}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);

      run_muldiv(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_muldiv(FN_MULT, -32'sd3, 32'd7);
      run_muldiv(FN_DIV, -32'sd7, 32'd2);
      run_muldiv(FN_DIVU, 32'd100, 32'd0);
      run_muldiv(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_muldiv(FN_DIV, 32'hFFFF_FFF9, 32'd0);

      // MTHI then MTLO on back-to-back cycles
      @(negedge clk);
      start = 1'b1; funct = FN_MTHI; operand_1 = 32'h1234_5678;
      #1 chk("stall_mthi", {63'd0, stall_request}, 64'd0);
      @(negedge clk);
      chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
      funct = FN_MTLO; operand_1 = 32'h9ABC_DEF0;
      #1 chk("stall_mtlo", {63'd0, stall_request}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
      chk("mtlo_hilo", {hi, lo}, {m_hi, m_lo});

      // Flush part-way through a divide
      @(negedge clk);
      start = 1'b1; funct = FN_DIVU; operand_1 = 32'd50; operand_2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1 chk("stall_flush", {63'd0, stall_request}, 64'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_stall", {63'd0, stall_request}, 64'd0);
      chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
      run_muldiv(FN_MULTU, 32'd6, 32'd7);

      // Flush in IDLE suppresses both MTHI and a multiply start
      @(negedge clk);
      flush = 1'b1; start = 1'b1; funct = FN_MTHI; operand_1 = 32'hDEAD_BEEF;
      #1 chk("flush_idle_stall_mt", {63'd0, stall_request}, 64'd0);
      @(negedge clk);
      funct = FN_MULT;
      #1 chk("flush_idle_stall_mul", {63'd0, stall_request}, 64'd0);
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      chk("flush_idle_busy", {63'd0, busy}, 64'd0);
      chk("flush_idle_hilo", {hi, lo}, {m_hi, m_lo});

      // Randomized mix of all operations plus ignored functs
      for (int i = 0; i < 30; i++) begin
         k = $urandom_range(0, 6);
         if (k < 4) begin
            run_muldiv(fsel[k], pick_operand(), pick_operand());
         end else if (k == 4) begin
            run_single(FN_MTHI, $urandom);
         end else if (k == 5) begin
            run_single(FN_MTLO, $urandom);
         end else begin
            f = 6'($urandom);
            if (f[5:2] == 4'b0110 || f == FN_MTHI || f == FN_MTLO) f = 6'h10;
            run_single(f, $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
